// File: rtl/gnn_pkg.sv
// Shared GNN datapath types: feature-vector sizing, bank/SRAM beat payloads and
// the write-back arbiter state encoding.
package gnn_pkg;

    localparam int unsigned FV_size     = 16;
    localparam int unsigned Max_Node_id = 256;
    localparam int unsigned MAX_FV_num  = 128;
    localparam int unsigned NID_W       = $clog2(Max_Node_id);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        GRANT  = 2'd1,
        STREAM = 2'd2
    } arb_state_e;

    // One 2-lane beat leaving an edge PE towards its buffer bank.
    typedef struct packed {
        logic                 valid;
        logic                 sos;
        logic                 eos;
        logic [2*FV_size-1:0] data;
        logic [NID_W-1:0]     node_id;
    } Edge_PE2Bank;

    // One 2-lane beat leaving a bank towards the output SRAM write port.
    typedef struct packed {
        logic                 valid;
        logic                 sos;
        logic                 eos;
        logic [2*FV_size-1:0] data;
        logic [NID_W-1:0]     node_id;
    } Bank_Req2Req_Output_SRAM;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, cyclically.
module rr_priority_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N);
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_bank_wb_arbiter.sv
// Round-robin arbiter sharing the output-SRAM write port among edge-buffer banks;
// the winning bank's sos..eos burst is muxed onto the SRAM request bus.
module edge_bank_wb_arbiter
    import gnn_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned FV_SIZE   = FV_size,
    parameter int unsigned NODE_ID_W = NID_W,
    parameter int unsigned MAX_BEATS = MAX_FV_num / 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_BANKS-1:0]             bank_req,
    output logic [NUM_BANKS-1:0]             bank_grant,
    input  logic [NUM_BANKS-1:0]             bank_valid,
    input  logic [NUM_BANKS-1:0]             bank_sos,
    input  logic [NUM_BANKS-1:0]             bank_eos,
    input  logic [NUM_BANKS*2*FV_SIZE-1:0]   bank_data,
    input  logic [NUM_BANKS*NODE_ID_W-1:0]   bank_node_id,
    input  logic                             sram_busy,
    output logic                             out_valid,
    output logic                             out_sos,
    output logic                             out_eos,
    output logic [2*FV_SIZE-1:0]             out_data,
    output logic [NODE_ID_W-1:0]             out_node_id,
    output logic                             err_proto,
    output logic                             err_timeout
);

    localparam int unsigned IDX_W  = $clog2(NUM_BANKS);
    localparam int unsigned CNT_W  = $clog2(MAX_BEATS + 1);
    localparam int unsigned DATA_W = 2 * FV_SIZE;

    arb_state_e           state;
    logic [IDX_W-1:0]     owner;
    logic [NUM_BANKS-1:0] owner_oh;
    logic [IDX_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]     beat_cnt;

    logic [NUM_BANKS-1:0] pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;

    logic                 own_valid;
    logic                 own_sos;
    logic                 own_eos;
    logic [DATA_W-1:0]    own_data;
    logic [NODE_ID_W-1:0] own_node_id;

    logic [IDX_W-1:0]     next_ptr;
    logic                 abort;

    rr_priority_pick #(.N(NUM_BANKS)) u_pick (
        .req    (bank_req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Owner's beat; all other banks are don't-care.
    always_comb begin
        own_valid   = 1'b0;
        own_sos     = 1'b0;
        own_eos     = 1'b0;
        own_data    = '0;
        own_node_id = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (IDX_W'(b) == owner) begin
                own_valid   = bank_valid[b];
                own_sos     = bank_sos[b];
                own_eos     = bank_eos[b];
                own_data    = bank_data[b*DATA_W +: DATA_W];
                own_node_id = bank_node_id[b*NODE_ID_W +: NODE_ID_W];
            end
        end
    end

    assign next_ptr = (32'(owner) == NUM_BANKS - 1) ? '0 : owner + 1'b1;
    assign abort    = (state == STREAM) && (beat_cnt == CNT_W'(MAX_BEATS))
                      && !(own_valid && own_eos);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARB;
            owner       <= '0;
            owner_oh    <= '0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            err_proto   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    if (pick_valid && !sram_busy) begin
                        owner    <= pick_idx;
                        owner_oh <= pick_onehot;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (own_valid && own_sos) begin
                        if (own_eos) begin
                            rr_ptr <= next_ptr;
                            state  <= ARB;
                        end else begin
                            beat_cnt <= CNT_W'(1);
                            state    <= STREAM;
                        end
                    end else begin
                        err_proto <= 1'b1;
                        rr_ptr    <= next_ptr;
                        state     <= ARB;
                    end
                end
                STREAM: begin
                    if ((own_valid && own_eos) || abort) begin
                        err_timeout <= err_timeout | abort;
                        beat_cnt    <= '0;
                        rr_ptr      <= next_ptr;
                        state       <= ARB;
                    end else if (own_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // Zero-latency forwarding of the owner's beat; idle bus while arbitrating.
    always_comb begin
        bank_grant  = '0;
        out_valid   = 1'b0;
        out_sos     = 1'b0;
        out_eos     = 1'b0;
        out_data    = '0;
        out_node_id = '0;
        if (state == GRANT) begin
            bank_grant = owner_oh;
        end
        if (state != ARB) begin
            out_valid   = own_valid;
            out_sos     = own_sos;
            out_eos     = own_eos | abort;
            out_data    = own_data;
            out_node_id = own_node_id;
        end
    end

endmodule

// File: tb/tb_edge_bank_wb_arbiter.sv
// Self-checking bench: directed vector table, round-robin order sequence, and
// randomized traffic against a burst-level reference model.
module tb_edge_bank_wb_arbiter;

    localparam int NB   = 4;
    localparam int FVS  = 16;
    localparam int NIW  = 8;
    localparam int MAXB = 4;
    localparam int DW   = 2 * FVS;

    logic            clk = 1'b0;
    logic            reset;
    logic [NB-1:0]   bank_req, bank_grant, bank_valid, bank_sos, bank_eos;
    logic [NB*DW-1:0]  bank_data;
    logic [NB*NIW-1:0] bank_node_id;
    logic            sram_busy;
    logic            out_valid, out_sos, out_eos;
    logic [DW-1:0]   out_data;
    logic [NIW-1:0]  out_node_id;
    logic            err_proto, err_timeout;

    edge_bank_wb_arbiter #(
        .NUM_BANKS(NB), .FV_SIZE(FVS), .NODE_ID_W(NIW), .MAX_BEATS(MAXB)
    ) dut (
        .clk(clk), .reset(reset),
        .bank_req(bank_req), .bank_grant(bank_grant),
        .bank_valid(bank_valid), .bank_sos(bank_sos), .bank_eos(bank_eos),
        .bank_data(bank_data), .bank_node_id(bank_node_id),
        .sram_busy(sram_busy),
        .out_valid(out_valid), .out_sos(out_sos), .out_eos(out_eos),
        .out_data(out_data), .out_node_id(out_node_id),
        .err_proto(err_proto), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef logic [48:0] obs_t;   // {grant, valid, sos, eos, data, node_id, err_proto, err_timeout}

    typedef struct {
        bit          rst;
        logic [3:0]  req;
        bit          busy;
        int          b;
        bit          v, s, e;
        logic [3:0]  g;
        bit          fwd, oe, ep, et;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: which bank owns the port, whether this is its grant cycle,
    // beats already forwarded, next round-robin start and sticky errors.
    int m_cur = -1;
    bit m_in_grant = 1'b0;
    int m_beats = 0;
    int m_ptr = 0;
    bit m_ep = 1'b0;
    bit m_et = 1'b0;

    function automatic void add(bit rst, logic [3:0] req, bit busy, int b, bit v, bit s, bit e,
                                logic [3:0] g, bit fwd, bit oe, bit ep, bit et);
        vec_t r;
        r.rst = rst; r.req = req; r.busy = busy; r.b = b; r.v = v; r.s = s; r.e = e;
        r.g = g; r.fwd = fwd; r.oe = oe; r.ep = ep; r.et = et;
        vecs.push_back(r);
    endfunction

    function automatic obs_t dut_obs();
        return {bank_grant, out_valid, out_sos, out_eos, out_data, out_node_id, err_proto, err_timeout};
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t got;
        got = dut_obs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    function automatic obs_t m_expect();
        logic [3:0]     g;
        logic           v, s, e, ab;
        logic [DW-1:0]  d;
        logic [NIW-1:0] n;
        if (m_cur < 0) return {47'b0, m_ep, m_et};
        v  = bank_valid[m_cur];
        s  = bank_sos[m_cur];
        e  = bank_eos[m_cur];
        ab = !m_in_grant && (m_beats == MAXB) && !(v && e);
        g  = m_in_grant ? 4'(1 << m_cur) : 4'b0;
        d  = bank_data[m_cur*DW +: DW];
        n  = bank_node_id[m_cur*NIW +: NIW];
        return {g, v, s, e | ab, d, n, m_ep, m_et};
    endfunction

    function automatic void m_release();
        m_ptr = (m_cur + 1) % NB;
        m_cur = -1;
    endfunction

    function automatic void m_update();
        logic v, s, e;
        if (reset) begin
            m_cur = -1; m_ptr = 0; m_beats = 0; m_ep = 1'b0; m_et = 1'b0;
        end else if (m_cur < 0) begin
            if (bank_req != 0 && !sram_busy) begin
                for (int k = 0; k < NB; k++) begin
                    if (m_cur < 0 && bank_req[(m_ptr + k) % NB]) m_cur = (m_ptr + k) % NB;
                end
                m_in_grant = 1'b1;
            end
        end else begin
            v = bank_valid[m_cur]; s = bank_sos[m_cur]; e = bank_eos[m_cur];
            if (m_in_grant) begin
                if (!(v && s)) begin
                    m_ep = 1'b1;
                    m_release();
                end else if (e) begin
                    m_release();
                end else begin
                    m_in_grant = 1'b0;
                    m_beats = 1;
                end
            end else if (v && e) begin
                m_release();
            end else if (m_beats == MAXB) begin
                m_et = 1'b1;
                m_release();
            end else if (v) begin
                m_beats++;
            end
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int act, viol, got;
    vec_t r;
    logic [DW-1:0]  d;
    logic [NIW-1:0] n;

    initial begin
        // rst req busy bank v s e | grant fwd oeos ep et
        add(0, 4'b0000, 0, 2, 0, 0, 0, 4'b0000, 0, 0, 0, 0);  // reset state
        add(0, 4'b0100, 0, 2, 0, 0, 0, 4'b0000, 0, 0, 0, 0);  // bank2 requests
        add(0, 4'b0100, 0, 2, 1, 1, 0, 4'b0100, 1, 0, 0, 0);
        add(0, 4'b0100, 0, 2, 1, 0, 0, 4'b0000, 1, 0, 0, 0);
        add(0, 4'b0100, 0, 2, 1, 0, 0, 4'b0000, 1, 0, 0, 0);
        add(0, 4'b0000, 0, 2, 1, 0, 1, 4'b0000, 1, 1, 0, 0);
        add(0, 4'b0000, 0, 2, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 4'b0010, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);  // sram_busy holds off
        add(0, 4'b0010, 0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0000, 0, 1, 1, 1, 1, 4'b0010, 1, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0001, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);  // bank0 omits sos
        add(0, 4'b0000, 0, 0, 1, 0, 0, 4'b0001, 1, 0, 0, 0);
        add(0, 4'b0011, 0, 1, 0, 0, 0, 4'b0000, 0, 0, 1, 0);
        add(0, 4'b0000, 0, 1, 1, 1, 1, 4'b0010, 1, 1, 1, 0);
        add(0, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 0, 0, 1, 0);
        add(0, 4'b1000, 0, 3, 0, 0, 0, 4'b0000, 0, 0, 1, 0);  // bank3 overruns
        add(0, 4'b1000, 0, 3, 1, 1, 0, 4'b1000, 1, 0, 1, 0);
        add(0, 4'b0000, 0, 3, 1, 0, 0, 4'b0000, 1, 0, 1, 0);
        add(0, 4'b0000, 0, 3, 1, 0, 0, 4'b0000, 1, 0, 1, 0);
        add(0, 4'b0000, 0, 3, 1, 0, 0, 4'b0000, 1, 0, 1, 0);
        add(0, 4'b0000, 0, 3, 1, 0, 0, 4'b0000, 1, 1, 1, 0);
        add(0, 4'b0000, 0, 3, 1, 0, 0, 4'b0000, 0, 0, 1, 1);
        add(0, 4'b0000, 0, 3, 1, 0, 1, 4'b0000, 0, 0, 1, 1);
        add(0, 4'b0001, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 1);  // bank0 single beat
        add(0, 4'b0000, 0, 0, 1, 1, 1, 4'b0001, 1, 1, 1, 1);
        add(0, 4'b0100, 0, 2, 0, 0, 0, 4'b0000, 0, 0, 1, 1);  // bank2, reset on beat 2
        add(0, 4'b0000, 0, 2, 1, 1, 0, 4'b0100, 1, 0, 1, 1);
        add(0, 4'b0000, 0, 2, 1, 0, 0, 4'b0000, 1, 0, 1, 1);
        add(1, 4'b0000, 0, 2, 1, 0, 0, 4'b0000, 1, 0, 1, 1);
        add(0, 4'b0000, 0, 2, 1, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b1111, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b1111, 0, 0, 1, 1, 1, 4'b0001, 1, 1, 0, 0);  // rr_ptr back at 0

        reset = 1'b1; bank_req = '0; sram_busy = 1'b0;
        bank_valid = '0; bank_sos = '0; bank_eos = '0; bank_data = '0; bank_node_id = '0;
        cycle();
        cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            r = vecs[i];
            reset = r.rst; bank_req = r.req; sram_busy = r.busy;
            bank_valid = 4'hF; bank_sos = 4'hF; bank_eos = 4'hF;
            bank_data = {4{32'hDEADBEEF}}; bank_node_id = {4{8'hEE}};
            d = {8'(i), 8'(r.b), 16'h5A5A};
            n = 8'(i + 16);
            bank_valid[r.b] = r.v; bank_sos[r.b] = r.s; bank_eos[r.b] = r.e;
            bank_data[r.b*DW +: DW] = d;
            bank_node_id[r.b*NIW +: NIW] = n;
            #1;
            check($sformatf("vec%0d", i),
                  {r.g, r.fwd & r.v, r.fwd & r.s, r.oe, r.fwd ? d : 32'h0, r.fwd ? n : 8'h0, r.ep, r.et});
            cycle();
        end

        // All banks request continuously with 2-beat bursts.
        reset = 1'b1; bank_req = '0;
        bank_valid = '0; bank_sos = '0; bank_eos = '0;
        cycle();
        reset = 1'b0; bank_req = 4'hF;
        act = -1; viol = 0;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            bank_valid = '0; bank_sos = '0; bank_eos = '0;
            bank_data = {$urandom, $urandom, $urandom, $urandom};
            if (act >= 0) begin
                if (bank_grant != 0) viol++;
                bank_valid[act] = 1'b1; bank_eos[act] = 1'b1;
                act = -1;
            end else if (bank_grant != 0) begin
                for (int k = 0; k < NB; k++) if (bank_grant[k]) act = k;
                order.push_back(act);
                bank_valid[act] = 1'b1; bank_sos[act] = 1'b1;
            end
            cycle();
        end
        for (int i = 0; i < 5; i++) begin
            got = (i < order.size()) ? order[i] : -1;
            checks++;
            if (got != exp_order[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got bank %0d want bank %0d", i, got, exp_order[i]);
            end
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL grant_while_streaming: got %0d grants want 0", viol);
        end

        // Randomized traffic against the reference model.
        reset = 1'b1; bank_req = '0;
        cycle();
        for (int c = 0; c < 500; c++) begin
            reset        = ($urandom % 50) == 0;
            bank_req     = 4'($urandom);
            sram_busy    = ($urandom % 4) == 0;
            bank_valid   = 4'($urandom | $urandom);
            bank_sos     = 4'($urandom);
            bank_eos     = 4'($urandom & $urandom);
            bank_data    = {$urandom, $urandom, $urandom, $urandom};
            bank_node_id = $urandom;
            #1;
            check($sformatf("rand%0d", c), m_expect());
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
